// File: rtl/temp_poll_bcd_if.sv
// Bus bundle between temp_poll_bcd and its environment.
// The bundle carries everything except the clock and reset.
//   en          : polling enable (into the poller)
//   temp_in     : raw DS18B20 controller temperature output (into the poller)
//   start       : one-cycle start pulse to the controller
//   temp_raw    : last accepted raw reading
//   sign        : 1 = negative reading
//   bcd_int     : integer magnitude, 3 BCD digits
//   bcd_frac    : tenths digit, BCD
//   temp_valid  : outputs hold a good reading
//   sensor_err  : last sample was 0xFFFF (dead bus)
//   data_strobe : one-cycle pulse when the outputs update
//   alarm       : hysteretic over-temperature flag
// The poller uses the slave modport. The environment (controller, display
// path or bench) uses the master modport.
interface temp_poll_bcd_if;
    logic        en;
    logic [15:0] temp_in;
    logic        start;
    logic [15:0] temp_raw;
    logic        sign;
    logic [11:0] bcd_int;
    logic [3:0]  bcd_frac;
    logic        temp_valid;
    logic        sensor_err;
    logic        data_strobe;
    logic        alarm;

    modport master (
        output en, temp_in,
        input  start, temp_raw, sign, bcd_int, bcd_frac,
               temp_valid, sensor_err, data_strobe, alarm
    );

    modport slave (
        input  en, temp_in,
        output start, temp_raw, sign, bcd_int, bcd_frac,
               temp_valid, sensor_err, data_strobe, alarm
    );
endinterface

// File: rtl/temp_poll_bcd.sv
// temp_poll_bcd: periodic poller for the DS18B20 controller.
// The module pulses start every POLL_PERIOD_CYC cycles. It samples temp_in
// CAPTURE_DELAY_CYC cycles after each start pulse. It then converts the
// 12-bit two's-complement reading (LSB = 1/16 degC) into a sign, a 3-digit
// BCD integer part and a 1-digit BCD tenths part.
//
// Ports:
//   CLK_10MHZ : system clock
//   RST       : synchronous active-high reset
//   bus       : temp_poll_bcd_if.slave (en, temp_in in; start and results out)
//
// Optional feature: define TEMP_ALARM_EN to build the hysteretic
// over-temperature alarm. The ALARM_HI and ALARM_LO parameters exist only
// in that build. Without it, alarm is tied to 0.
module temp_poll_bcd #(
    parameter int unsigned POLL_PERIOD_CYC   = 10000000,
    parameter int unsigned CAPTURE_DELAY_CYC = 500000
`ifdef TEMP_ALARM_EN
    ,
    parameter logic signed [15:0] ALARM_HI = 16'sh0500,
    parameter logic signed [15:0] ALARM_LO = 16'sh0460
`endif
) (
    input  logic         CLK_10MHZ,
    input  logic         RST,
    temp_poll_bcd_if.slave bus
);

    localparam int unsigned TW = (POLL_PERIOD_CYC > 2)   ? $clog2(POLL_PERIOD_CYC)   : 1;
    localparam int unsigned CW = (CAPTURE_DELAY_CYC > 2) ? $clog2(CAPTURE_DELAY_CYC) : 1;

    typedef enum logic [2:0] {
        WAIT_POLL,
        START,
        WAIT_CAP,
        CAPTURE_CHK,
        PREP,
        CONVERT,
        COMMIT
    } state_t;

    state_t state, state_next;

    logic [TW-1:0] timer;
    logic [CW-1:0] cap_cnt;
    logic          discard;
    logic [15:0]   hold_raw;
    logic          sign_n;
    logic [7:0]    int8;
    logic [3:0]    frac_n;
    logic [19:0]   dd;
    logic [19:0]   dd_adj;
    logic [19:0]   dd_next;
    logic [2:0]    bit_cnt;
    logic [11:0]   mag12;
    logic [3:0]    frac_calc;

    logic [15:0]   temp_raw_r;
    logic          sign_r;
    logic [11:0]   bcd_int_r;
    logic [3:0]    bcd_frac_r;
    logic          temp_valid_r;
    logic          sensor_err_r;
    logic          data_strobe_r;

    logic issue;
    logic err_path;
    logic last_shift;

    // State register
    always_ff @(posedge CLK_10MHZ) begin
        if (RST) begin
            state <= WAIT_POLL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and control decodes
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        err_path   = 1'b0;
        last_shift = 1'b0;
        case (state)
            WAIT_POLL: begin
                if (bus.en && (timer == '0)) begin
                    state_next = START;
                    issue      = 1'b1;
                end
            end
            START: state_next = WAIT_CAP;
            WAIT_CAP: begin
                if (cap_cnt == '0) state_next = CAPTURE_CHK;
            end
            CAPTURE_CHK: begin
                if (discard) begin
                    state_next = WAIT_POLL;
                end else if (hold_raw == 16'hFFFF) begin
                    state_next = WAIT_POLL;
                    err_path   = 1'b1;
                end else begin
                    state_next = PREP;
                end
            end
            PREP: state_next = CONVERT;
            CONVERT: begin
                if (bit_cnt == 3'd7) begin
                    state_next = COMMIT;
                    last_shift = 1'b1;
                end
            end
            COMMIT:  state_next = WAIT_POLL;
            default: state_next = WAIT_POLL;
        endcase
    end

    // Magnitude of the 12-bit reading. The low 12 bits of -raw depend only
    // on raw[11:0], so the full 16-bit negate is not needed.
    always_comb begin
        mag12 = hold_raw[15] ? (~hold_raw[11:0] + 12'd1) : hold_raw[11:0];
    end

    // Tenths = floor(frac16 * 10 / 16)
    always_comb begin
        case (mag12[3:0])
            4'd0, 4'd1:         frac_calc = 4'd0;
            4'd2, 4'd3:         frac_calc = 4'd1;
            4'd4:               frac_calc = 4'd2;
            4'd5, 4'd6:         frac_calc = 4'd3;
            4'd7:               frac_calc = 4'd4;
            4'd8, 4'd9:         frac_calc = 4'd5;
            4'd10, 4'd11:       frac_calc = 4'd6;
            4'd12:              frac_calc = 4'd7;
            4'd13, 4'd14:       frac_calc = 4'd8;
            default:            frac_calc = 4'd9;
        endcase
    end

    // One double-dabble step: add 3 to each BCD digit >= 5, then shift left
    always_comb begin
        dd_adj = dd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (dd_adj[8 + 4*i +: 4] >= 4'd5) begin
                dd_adj[8 + 4*i +: 4] = dd_adj[8 + 4*i +: 4] + 4'd3;
            end
        end
        dd_next = dd_adj << 1;
    end

    // Datapath. The results and data_strobe are registered on the edge that
    // ends the last CONVERT cycle. They therefore appear together during the
    // COMMIT cycle, 11 cycles after capture.
    always_ff @(posedge CLK_10MHZ) begin
        if (RST) begin
            timer         <= '0;
            cap_cnt       <= '0;
            discard       <= 1'b1;
            hold_raw      <= '0;
            sign_n        <= 1'b0;
            int8          <= '0;
            frac_n        <= '0;
            dd            <= '0;
            bit_cnt       <= '0;
            temp_raw_r    <= '0;
            sign_r        <= 1'b0;
            bcd_int_r     <= '0;
            bcd_frac_r    <= '0;
            temp_valid_r  <= 1'b0;
            sensor_err_r  <= 1'b0;
            data_strobe_r <= 1'b0;
        end else begin
            data_strobe_r <= 1'b0;

            // The timer is loaded as START is entered, so the pulses are
            // exactly POLL_PERIOD_CYC cycles apart.
            if (issue) begin
                timer <= TW'(POLL_PERIOD_CYC - 1);
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end

            if (state == START) begin
                cap_cnt <= CW'(CAPTURE_DELAY_CYC - 1);
            end else if ((state == WAIT_CAP) && (cap_cnt != '0)) begin
                cap_cnt <= cap_cnt - 1'b1;
            end

            if ((state == WAIT_CAP) && (cap_cnt == '0)) begin
                hold_raw <= bus.temp_in;
            end

            if (state == CAPTURE_CHK) begin
                if (discard) begin
                    discard <= 1'b0;
                end else if (err_path) begin
                    sensor_err_r  <= 1'b1;
                    temp_valid_r  <= 1'b0;
                    data_strobe_r <= 1'b1;
                end else begin
                    sign_n <= hold_raw[15];
                    int8   <= mag12[11:4];
                    frac_n <= frac_calc;
                end
            end

            if (state == PREP) begin
                dd      <= {12'd0, int8};
                bit_cnt <= '0;
            end

            if (state == CONVERT) begin
                dd      <= dd_next;
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (last_shift) begin
                temp_raw_r    <= hold_raw;
                sign_r        <= sign_n;
                bcd_int_r     <= dd_next[19:8];
                bcd_frac_r    <= frac_n;
                temp_valid_r  <= 1'b1;
                sensor_err_r  <= 1'b0;
                data_strobe_r <= 1'b1;
            end
        end
    end

`ifdef TEMP_ALARM_EN
    logic alarm_r;

    // Hysteresis: set at or above HI, clear at or below LO, hold in between
    always_ff @(posedge CLK_10MHZ) begin
        if (RST) begin
            alarm_r <= 1'b0;
        end else if (last_shift) begin
            if ($signed(hold_raw) >= ALARM_HI) begin
                alarm_r <= 1'b1;
            end else if ($signed(hold_raw) <= ALARM_LO) begin
                alarm_r <= 1'b0;
            end
        end
    end

    assign bus.alarm = alarm_r;
`else
    assign bus.alarm = 1'b0;
`endif

    assign bus.start       = (state == START);
    assign bus.temp_raw    = temp_raw_r;
    assign bus.sign        = sign_r;
    assign bus.bcd_int     = bcd_int_r;
    assign bus.bcd_frac    = bcd_frac_r;
    assign bus.temp_valid  = temp_valid_r;
    assign bus.sensor_err  = sensor_err_r;
    assign bus.data_strobe = data_strobe_r;

endmodule

// File: tb/tb_temp_poll_bcd.sv
// Directed testbench for temp_poll_bcd.
// The DUT runs with POLL_PERIOD_CYC=100 and CAPTURE_DELAY_CYC=20.
// Expected values are computed by hand.
module tb_temp_poll_bcd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    temp_poll_bcd_if bus();

    temp_poll_bcd #(
        .POLL_PERIOD_CYC  (100),
        .CAPTURE_DELAY_CYC(20)
    ) dut (
        .CLK_10MHZ(clk),
        .RST      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef TEMP_ALARM_EN
    localparam logic [2:0] ALARM_EXP = 3'b110;
`else
    localparam logic [2:0] ALARM_EXP = 3'b000;
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Wait for a start pulse; reports its cycle and the strobes seen meanwhile
    task automatic wait_start(input int bound, output int t, output bit ok, output int ns);
        ok = 1'b0; t = 0; ns = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (bus.data_strobe) ns++;
            if (bus.start) begin ok = 1'b1; t = cyc; end
        end
    endtask

    task automatic wait_strobe(input int bound, output int t, output bit ok);
        ok = 1'b0; t = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (bus.data_strobe) begin ok = 1'b1; t = cyc; end
        end
    endtask

    // Present a value, wait for the next start and the resulting strobe
    task automatic sample(input logic [15:0] val, output int lat, output bit ok);
        int ts, te, ns;
        bit oks, oke;
        bus.temp_in = val;
        wait_start(150, ts, oks, ns);
        wait_strobe(60, te, oke);
        ok  = oks && oke;
        lat = te - ts;
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.en = 1'b0; bus.temp_in = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if ({bus.start, bus.data_strobe, bus.temp_valid, bus.sensor_err, bus.alarm, bus.sign} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000", {bus.start, bus.data_strobe, bus.temp_valid, bus.sensor_err, bus.alarm, bus.sign}); end
        checks++; if (bus.temp_raw !== 16'h0000) begin errors++; $display("FAIL reset_raw: got %h expected 0000", bus.temp_raw); end
        checks++; if ({bus.bcd_int, bus.bcd_frac} !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", {bus.bcd_int, bus.bcd_frac}); end
    endtask

    // First capture after reset is discarded; start period is 100 cycles
    task automatic test_first_discard;
        int t0, t1, t2, ns;
        bit ok;
        rst = 1'b0; bus.en = 1'b1; bus.temp_in = 16'h1234;
        t0 = cyc;
        wait_start(10, t1, ok, ns);
        checks++; if (!ok || (t1 - t0) !== 1) begin errors++; $display("FAIL first_start: got ok=%0d delay=%0d expected delay 1", ok, t1 - t0); end
        repeat (25) @(negedge clk);
        bus.temp_in = 16'h0191;
        wait_start(150, t2, ok, ns);
        checks++; if (!ok || (t2 - t1) !== 100) begin errors++; $display("FAIL poll_period: got %0d expected 100", t2 - t1); end
        checks++; if (ns !== 0) begin errors++; $display("FAIL discard_strobe: got %0d strobes expected 0", ns); end
        checks++; if (bus.temp_valid !== 1'b0) begin errors++; $display("FAIL discard_valid: got %b expected 0", bus.temp_valid); end
    endtask

    // Second capture (0x0191 = 25.0625 degC) commits 31 cycles after start
    task automatic test_convert_positive;
        int te;
        bit ok;
        wait_strobe(60, te, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pos_strobe: got none expected pulse"); end
        checks++; if ({bus.sign, bus.bcd_int, bus.bcd_frac} !== {1'b0, 12'h025, 4'h0}) begin
            errors++; $display("FAIL pos_value: got s=%b %h.%h expected s=0 025.0", bus.sign, bus.bcd_int, bus.bcd_frac); end
        checks++; if ({bus.temp_valid, bus.sensor_err, bus.temp_raw} !== {1'b1, 1'b0, 16'h0191}) begin
            errors++; $display("FAIL pos_status: got v=%b e=%b raw=%h expected v=1 e=0 raw=0191", bus.temp_valid, bus.sensor_err, bus.temp_raw); end
        @(negedge clk);
        checks++; if (bus.data_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", bus.data_strobe); end
    endtask

    task automatic test_convert_values;
        int lat;
        bit ok;
        sample(16'hFF5E, lat, ok);
        checks++; if (!ok || lat !== 31) begin errors++; $display("FAIL latency: got ok=%0d lat=%0d expected 31", ok, lat); end
        checks++; if ({bus.sign, bus.bcd_int, bus.bcd_frac} !== {1'b1, 12'h010, 4'h1}) begin
            errors++; $display("FAIL neg_value: got s=%b %h.%h expected s=1 010.1", bus.sign, bus.bcd_int, bus.bcd_frac); end
        sample(16'h07D0, lat, ok);
        checks++; if (!ok || {bus.sign, bus.bcd_int, bus.bcd_frac} !== {1'b0, 12'h125, 4'h0}) begin
            errors++; $display("FAIL max_value: got s=%b %h.%h expected s=0 125.0", bus.sign, bus.bcd_int, bus.bcd_frac); end
        sample(16'h000F, lat, ok);
        checks++; if (!ok || {bus.sign, bus.bcd_int, bus.bcd_frac} !== {1'b0, 12'h000, 4'h9}) begin
            errors++; $display("FAIL frac_value: got s=%b %h.%h expected s=0 000.9", bus.sign, bus.bcd_int, bus.bcd_frac); end
    endtask

    task automatic test_sensor_error;
        int lat;
        bit ok;
        sample(16'h0191, lat, ok);
        sample(16'hFFFF, lat, ok);
        checks++; if (!ok || lat !== 22) begin errors++; $display("FAIL err_latency: got ok=%0d lat=%0d expected 22", ok, lat); end
        checks++; if ({bus.sensor_err, bus.temp_valid} !== 2'b10) begin
            errors++; $display("FAIL err_flags: got e=%b v=%b expected e=1 v=0", bus.sensor_err, bus.temp_valid); end
        checks++; if ({bus.bcd_int, bus.temp_raw} !== {12'h025, 16'h0191}) begin
            errors++; $display("FAIL err_hold: got %h raw=%h expected 025 raw=0191", bus.bcd_int, bus.temp_raw); end
        sample(16'h0191, lat, ok);
        checks++; if (!ok || {bus.sensor_err, bus.temp_valid} !== 2'b01) begin
            errors++; $display("FAIL err_clear: got e=%b v=%b expected e=0 v=1", bus.sensor_err, bus.temp_valid); end
    endtask

    task automatic test_alarm;
        int lat;
        bit ok;
        logic [15:0] vals [3] = '{16'h0500, 16'h0480, 16'h0460};
        for (int i = 0; i < 3; i++) begin
            sample(vals[i], lat, ok);
            checks++; if (!ok || bus.alarm !== ALARM_EXP[2 - i]) begin
                errors++; $display("FAIL alarm_%0d: got %b expected %b", i, bus.alarm, ALARM_EXP[2 - i]); end
        end
    endtask

    task automatic test_reset_mid_convert;
        int ts, t1, t2, te, ns, t0;
        bit ok;
        bus.temp_in = 16'h07D0;
        wait_start(150, ts, ok, ns);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({bus.start, bus.data_strobe, bus.temp_valid, bus.sensor_err, bus.alarm, bus.sign, bus.temp_raw, bus.bcd_int, bus.bcd_frac} !== '0) begin
            errors++; $display("FAIL midrst_outputs: got v=%b raw=%h bcd=%h.%h expected all zero", bus.temp_valid, bus.temp_raw, bus.bcd_int, bus.bcd_frac); end
        rst = 1'b0;
        t0 = cyc;
        bus.temp_in = 16'h0191;
        wait_start(10, t1, ok, ns);
        checks++; if (!ok || (t1 - t0) !== 1) begin errors++; $display("FAIL midrst_restart: got ok=%0d delay=%0d expected delay 1", ok, t1 - t0); end
        wait_start(150, t2, ok, ns);
        checks++; if (!ok || ns !== 0 || bus.temp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_discard: got strobes=%0d v=%b expected 0 strobes v=0", ns, bus.temp_valid); end
        wait_strobe(60, te, ok);
        checks++; if (!ok || (te - t2) !== 31 || bus.bcd_int !== 12'h025) begin
            errors++; $display("FAIL midrst_resume: got lat=%0d bcd=%h expected lat=31 bcd=025", te - t2, bus.bcd_int); end
    endtask

    // en dropped right after a start: that conversion still commits, then no more starts
    task automatic test_en_low;
        int ts, te, t2, ns;
        bit ok, ok2;
        bus.temp_in = 16'h07D0;
        wait_start(150, ts, ok, ns);
        @(negedge clk);
        bus.en = 1'b0;
        wait_strobe(60, te, ok);
        checks++; if (!ok || (te - ts) !== 31 || bus.bcd_int !== 12'h125) begin
            errors++; $display("FAIL en_low_commit: got lat=%0d bcd=%h expected lat=31 bcd=125", te - ts, bus.bcd_int); end
        wait_start(250, t2, ok2, ns);
        checks++; if (ok2) begin errors++; $display("FAIL en_low_start: got start at %0d expected none", t2); end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.temp_in = 16'h0000;
        test_reset;
        test_first_discard;
        test_convert_positive;
        test_convert_values;
        test_sensor_error;
        test_alarm;
        test_reset_mid_convert;
        test_en_low;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
